// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: issues word-aligned memory requests with byte
// enables and lane-replicated store data, and aligns/extends returned load data.
//
// state | meaning
// IDLE  | ready for a new load/store from execute
// REQ   | memory request outstanding, waiting for dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// RESP  | one-cycle response toward writeback
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        dmem_req_q, dmem_we_q, resp_valid_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q, resp_data_q;
    logic [3:0]  dmem_be_q;
    logic [4:0]  resp_rd_q;
    logic [1:0]  resp_fault_q;

    logic        illegal_d, misaligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    function automatic logic [31:0] extract(input logic [31:0] rdata,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return sh;
            3'd4:    return {24'd0, sh[7:0]};
            3'd5:    return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        illegal_d    = req_store ? (req_funct3 >= 3'd3)
                                 : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        // Once illegal encodings are excluded, funct3[1:0] alone gives the access size.
        misaligned_d = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_be_q    <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= 32'd0;
            resp_fault_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q     <= req_store;
                        funct3_q    <= req_funct3;
                        off_q       <= req_addr[1:0];
                        resp_rd_q   <= req_rd;
                        resp_data_q <= 32'd0;
                        if (illegal_d || misaligned_d) begin
                            resp_fault_q <= illegal_d ? 2'b10 : 2'b01;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            resp_fault_q <= 2'b00;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= req_store;
                            dmem_addr_q  <= {req_addr[31:2], 2'b00};
                            dmem_wdata_q <= req_store ? wdata_d : 32'd0;
                            dmem_be_q    <= be_d;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (store_q) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        resp_data_q  <= extract(dmem_rdata, funct3_q, off_q);
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;
    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of operations driven through a
// memory responder, responses checked against a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [1:0]  fault;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] dwdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                fail_now("spurious_resp");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_fault", {30'd0, resp_fault}, {30'd0, e.fault});
                chk("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("ready_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            fail_now("resp_timeout");
            q.delete();
        end
    endtask

    task automatic do_op(input vec_t v, input logic [4:0] rd);
        exp_t e;
        logic stable;
        logic saw_req;
        wait_ready();
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
        e.data  = v.data;
        e.fault = v.fault;
        e.rd    = rd;
        e.acc   = cyc;
        e.lat   = (v.fault != 2'b00) ? 1 : (v.store ? 2 + v.gnt_dly : 3 + v.gnt_dly + v.rv_dly);
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        if (v.fault != 2'b00) begin
            saw_req = dmem_req;
            while (q.size() != 0 && cyc - e.acc < 10) begin
                @(negedge clk);
                saw_req = saw_req | dmem_req;
            end
            chk("fault_no_dmem_req", {31'd0, saw_req}, 32'd0);
        end else begin
            chk("dmem_req", {31'd0, dmem_req}, 32'd1);
            chk("dmem_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, v.store});
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, v.be});
            if (v.store) chk("dmem_wdata", dmem_wdata, v.dwdata);
            stable = 1'b1;
            for (int i = 0; i < v.gnt_dly; i++) begin
                @(negedge clk);
                if (!(dmem_req && dmem_addr == (v.addr & 32'hFFFF_FFFC) && dmem_be == v.be &&
                      dmem_we == v.store && (!v.store || dmem_wdata == v.dwdata)))
                    stable = 1'b0;
            end
            if (v.gnt_dly > 0) chk("stall_stable", {31'd0, stable}, 32'd1);
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
            if (!v.store) begin
                for (int i = 0; i < v.rv_dly; i++) @(negedge clk);
                dmem_rdata  = v.rdata;
                dmem_rvalid = 1'b1;
                @(negedge clk);
                dmem_rvalid = 1'b0;
                dmem_rdata  = $urandom;
            end
        end
        drain();
    endtask

    vec_t vecs[16];

    initial begin
        logic saw_resp;
        //           st  f3  addr          wdata         rdata         gd rv flt    data          be       dwdata
        vecs[0]  = '{0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 0, 2'b00, 32'hFFFF_FF80, 4'b1111, 32'h0};
        vecs[1]  = '{0, 3'd5, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 0, 2'b00, 32'h0000_BEEF, 4'b1111, 32'h0};
        vecs[2]  = '{0, 3'd1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 0, 2'b00, 32'hFFFF_BEEF, 4'b1111, 32'h0};
        vecs[3]  = '{1, 3'd0, 32'h0000_0011, 32'h1234_56AB, 32'h0,        0, 0, 2'b00, 32'h0,         4'b0010, 32'hABAB_ABAB};
        vecs[4]  = '{1, 3'd1, 32'h0000_0012, 32'h1234_56AB, 32'h0,        0, 0, 2'b00, 32'h0,         4'b1100, 32'h56AB_56AB};
        vecs[5]  = '{0, 3'd2, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 2'b01, 32'h0,         4'b1111, 32'h0};
        vecs[6]  = '{0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 2'b10, 32'h0,         4'b1111, 32'h0};
        vecs[7]  = '{1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4, 0, 2'b00, 32'h0,         4'b1111, 32'hDEAD_BEEF};
        vecs[8]  = '{0, 3'd4, 32'h0000_2001, 32'h0,        32'h1234_8000, 0, 2, 2'b00, 32'h0000_0080, 4'b1111, 32'h0};
        vecs[9]  = '{0, 3'd2, 32'h0000_3000, 32'h0,        32'hCAFE_F00D, 1, 1, 2'b00, 32'hCAFE_F00D, 4'b1111, 32'h0};
        vecs[10] = '{1, 3'd4, 32'h0000_0003, 32'h1111_1111, 32'h0,        0, 0, 2'b10, 32'h0,         4'b1111, 32'h0};
        vecs[11] = '{1, 3'd1, 32'h0000_0013, 32'h1111_1111, 32'h0,        0, 0, 2'b01, 32'h0,         4'b1111, 32'h0};
        vecs[12] = '{0, 3'd1, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 2'b01, 32'h0,         4'b1111, 32'h0};
        vecs[13] = '{1, 3'd0, 32'h0000_0012, 32'h0000_00C3, 32'h0,        0, 0, 2'b00, 32'h0,         4'b0100, 32'hC3C3_C3C3};
        vecs[14] = '{0, 3'd0, 32'h0000_0004, 32'h0,        32'h0000_007F, 0, 0, 2'b00, 32'h0000_007F, 4'b1111, 32'h0};
        vecs[15] = '{0, 3'd6, 32'h0000_0008, 32'h0,        32'h0,        0, 0, 2'b10, 32'h0,         4'b1111, 32'h0};

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_fault", {30'd0, resp_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) do_op(vecs[i], 5'(i + 1));

        // Reset while a load waits for data: no response, late rvalid ignored.
        wait_ready();
        req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_rd = 5'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wait_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rdata = 32'h5555_AAAA;
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_resp = saw_resp | resp_valid;
            @(negedge clk);
        end
        chk("wait_rst_no_resp", {31'd0, saw_resp}, 32'd0);
        chk("wait_rst_idle", {31'd0, req_ready}, 32'd1);

        // Reset while the request is outstanding drops dmem_req at once.
        req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'h1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_before_rst", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("req_rst_drop", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw_resp = saw_resp | resp_valid | dmem_req;
            @(negedge clk);
        end
        chk("req_rst_quiet", {31'd0, saw_resp}, 32'd0);

        // Normal operation resumes after the resets.
        do_op(vecs[0], 5'd31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core, sitting directly downstream of decode/execute. It accepts one load or store per transaction from execute (address already computed by the ALU), and generates word-aligned data-memory requests with byte enables and replicated store data. It aligns and sign/zero-extends load data, flags misaligned or illegal accesses without touching memory, and returns a single-cycle response toward register writeback.

## Interface
- No parameters; address and data widths are fixed at 32.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute presents a memory operation
- req_ready  out  1  unit can accept (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
- req_addr  in  32  effective byte address from ALU
- req_wdata  in  32  rs2 value for stores
- req_rd  in  5  destination register for loads
- dmem_req  out  1  memory request, held until granted
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address ({req_addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  memory accepted request this cycle
- dmem_rvalid  in  1  load data valid this cycle
- dmem_rdata  in  32  load word
- resp_valid  out  1  one-cycle completion pulse
- resp_rd  out  5  captured req_rd
- resp_data  out  32  extended load data; 0 for stores and faults
- resp_fault  out  2  00 ok, 01 misaligned, 10 illegal funct3

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture all request fields and decode:
  - illegal: load funct3 ∈ {3,6,7}; store funct3 ≥ 3 → fault 10, go to RESP.
  - misaligned: halfword with addr[0]=1; word with addr[1:0]≠0 → fault 01, go to RESP. Illegal takes priority.
  - otherwise go to REQ.
- REQ: dmem_req=1, dmem_* stable. On dmem_gnt: store → RESP; load → WAIT.
- WAIT: on dmem_rvalid, register extracted data, go to RESP. dmem_rvalid is ignored in every other state.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No backpressure on the response.
- Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; SW be=4'b1111, wdata unchanged.
- Load data: shifted = rdata >> (8*addr[1:0]); LB/LBU use shifted[7:0], LH/LHU use shifted[15:0], LW uses the full word. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Loads drive dmem_we=0, dmem_be=4'b1111.
- Faulted operations never assert dmem_req.

## Timing
- Reset (async assert): state=IDLE; dmem_req, dmem_we, resp_valid=0; dmem_addr, dmem_wdata, resp_data=0; dmem_be=0; resp_rd=0; resp_fault=00. req_ready=1 after reset deasserts.
- All dmem_* and resp_* outputs are registered; req_ready is a decode of state.
- Accept at cycle 0. dmem_req is high from cycle 1 until the cycle of dmem_gnt inclusive.
- Store, gnt in cycle 1 → resp_valid in cycle 2 (minimum latency 2).
- Load, gnt in cycle 1, rvalid earliest cycle 2 (never the gnt cycle) → resp_valid in cycle 3 (minimum latency 3).
- Fault → resp_valid in cycle 1.
- Each gnt or rvalid stall adds exactly one cycle per stalled cycle. No timeout.
- Back-to-back: next accept is possible in the cycle after resp_valid (IDLE).
- Reset mid-operation (REQ/WAIT/RESP): returns to IDLE immediately and drops dmem_req; no response is produced; a late rvalid is ignored.

## Test plan
- LB, addr=0x1003, rdata=0x80FF_0000 → dmem_addr=0x1000, be=1111, resp_data=0xFFFF_FF80, fault=00, resp_valid 3 cycles after accept.
- LHU, addr=0x2002, rdata=0xBEEF_1234 → resp_data=0x0000_BEEF; LH same inputs → 0xFFFF_BEEF.
- SB, addr=0x11, wdata=0x1234_56AB → dmem_addr=0x10, be=0010, wdata=0xABAB_ABAB, we=1; SH addr=0x12 → be=1100, wdata=0x56AB_56AB.
- LW addr=0x6 → fault=01, resp_valid next cycle, dmem_req never high; load funct3=3 → fault=10.
- dmem_gnt held low 4 cycles → dmem_req and its fields stay stable, and resp_valid is delayed by exactly 4 cycles.
- Assert rst_n low in WAIT, then pulse dmem_rvalid after release → no resp_valid, state IDLE, req_ready=1.
